// File: rtl/cnn_seq_pkg.sv
// Shared constants and state encoding for the CNN image sequencer.
package cnn_seq_pkg;

  localparam int IMG_PIXELS         = 784;   // 28x28 MNIST frame
  localparam int FLUSH_CYCLES_DEF   = 3;
  localparam int TIMEOUT_CYCLES_DEF = 8192;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_STREAM,
    ST_DRAIN,
    ST_WAIT_DEC,
    ST_REPORT,
    ST_DONE
  } seq_state_e;

endpackage

// File: rtl/cnn_image_sequencer_if.sv
// Bus between the sequencer, the image/label ROMs and the CNN datapath.
interface cnn_image_sequencer_if #(
  parameter int ADDR_BITS = 20,
  parameter int IMG_BITS  = 10
);
  logic                 mem_rd_en;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [7:0]           mem_rdata;
  logic [IMG_BITS-1:0]  label_addr;
  logic [3:0]           label_in;
  logic                 pipe_rst_n;
  logic [7:0]           pix_out;
  logic                 pix_valid;
  logic [3:0]           decision_in;
  logic                 decision_valid;

  // sequencer side
  modport master (
    output mem_rd_en, mem_addr, label_addr, pipe_rst_n, pix_out, pix_valid,
    input  mem_rdata, label_in, decision_in, decision_valid
  );

  // memory / datapath side
  modport slave (
    input  mem_rd_en, mem_addr, label_addr, pipe_rst_n, pix_out, pix_valid,
    output mem_rdata, label_in, decision_in, decision_valid
  );
endinterface

// File: rtl/cnn_pixel_streamer.sv
// Pixel address generation and the read-to-pixel pipeline. The memory
// returns data one cycle after rd_en; a second register stage feeds conv1,
// so pix_valid trails rd_en by exactly two cycles.
module cnn_pixel_streamer #(
  parameter int IMG_PIXELS   = 784,
  parameter int PIX_IDX_BITS = 10,
  parameter int ADDR_BITS    = 20
)(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rd_en,
  input  logic                 idx_clr,
  input  logic                 base_clr,
  input  logic                 base_inc,
  input  logic [7:0]           mem_rdata,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 last_rd,
  output logic [7:0]           pix_out,
  output logic                 pix_valid,
  output logic                 stream_done
);

  logic [PIX_IDX_BITS-1:0] idx_q, idx_d;
  logic [ADDR_BITS-1:0]    base_q, base_d;
  logic [7:0]              pix_q, pix_d;
  logic [2:1]              vld_q, vld_d;
  logic [2:0]              vld_pipe;

  // stage 0 is the read strobe itself, stages 1..2 are registered
  assign vld_pipe = {vld_q, rd_en};

  // next-state for index, base accumulator, valid shift and pixel register
  always_comb begin
    idx_d = idx_q;
    if (idx_clr)    idx_d = '0;
    else if (rd_en) idx_d = idx_q + 1'b1;

    // base advances by one frame per image, avoiding a multiplier
    base_d = base_q;
    if (base_clr)      base_d = '0;
    else if (base_inc) base_d = base_q + ADDR_BITS'(IMG_PIXELS);

    vld_d = vld_pipe[1:0];
    pix_d = vld_pipe[1] ? mem_rdata : pix_q;
  end

  // streamer registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q  <= '0;
      base_q <= '0;
      vld_q  <= '0;
      pix_q  <= '0;
    end else begin
      idx_q  <= idx_d;
      base_q <= base_d;
      vld_q  <= vld_d;
      pix_q  <= pix_d;
    end
  end

  assign mem_addr    = rd_en ? (base_q + ADDR_BITS'(idx_q)) : '0;
  assign last_rd     = rd_en && (idx_q == PIX_IDX_BITS'(IMG_PIXELS - 1));
  assign pix_out     = pix_q;
  assign pix_valid   = vld_q[2];
  // nothing left in flight behind the pixel currently on pix_out
  assign stream_done = ~vld_q[1];

endmodule

// File: rtl/cnn_image_sequencer.sv
// Batch controller: flush, stream, wait for decision, score, repeat.
module cnn_image_sequencer #(
  parameter int IMG_PIXELS     = cnn_seq_pkg::IMG_PIXELS,
  parameter int PIX_IDX_BITS   = 10,
  parameter int IMG_BITS       = 10,
  parameter int ADDR_BITS      = 20,
  parameter int FLUSH_CYCLES   = cnn_seq_pkg::FLUSH_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = cnn_seq_pkg::TIMEOUT_CYCLES_DEF
)(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [IMG_BITS-1:0]  num_img,
  cnn_image_sequencer_if.master bus,
  output logic                 busy,
  output logic                 result_valid,
  output logic                 result_match,
  output logic [IMG_BITS-1:0]  img_cnt,
  output logic [IMG_BITS-1:0]  hit_cnt,
  output logic                 timeout_err,
  output logic                 done
);
  import cnn_seq_pkg::*;

  localparam int FL_W  = $clog2(FLUSH_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  seq_state_e          state_q, state_d;
  logic [FL_W-1:0]     fl_q, fl_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [IMG_BITS-1:0] num_q, num_d;
  logic [IMG_BITS-1:0] idx_q, idx_d;
  logic [IMG_BITS-1:0] img_cnt_q, img_cnt_d;
  logic [IMG_BITS-1:0] hit_cnt_q, hit_cnt_d;
  logic [IMG_BITS-1:0] img_cnt_inc;
  logic                tmo_err_q, tmo_err_d;
  logic                match_q, match_d;
  logic                pipe_rst_n_q, pipe_rst_n_d;

  logic rd_en, idx_clr, base_clr, base_inc;
  logic last_rd, stream_done, tmo_hit, accept;

  assign accept      = (state_q == ST_IDLE) && start;
  assign tmo_hit     = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign img_cnt_inc = img_cnt_q + 1'b1;

  cnn_pixel_streamer #(
    .IMG_PIXELS   (IMG_PIXELS),
    .PIX_IDX_BITS (PIX_IDX_BITS),
    .ADDR_BITS    (ADDR_BITS)
  ) u_streamer (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_en       (rd_en),
    .idx_clr     (idx_clr),
    .base_clr    (base_clr),
    .base_inc    (base_inc),
    .mem_rdata   (bus.mem_rdata),
    .mem_addr    (bus.mem_addr),
    .last_rd     (last_rd),
    .pix_out     (bus.pix_out),
    .pix_valid   (bus.pix_valid),
    .stream_done (stream_done)
  );

  // state and scoreboard registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      fl_q         <= '0;
      tmo_q        <= '0;
      num_q        <= '0;
      idx_q        <= '0;
      img_cnt_q    <= '0;
      hit_cnt_q    <= '0;
      tmo_err_q    <= 1'b0;
      match_q      <= 1'b0;
      pipe_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fl_q         <= fl_d;
      tmo_q        <= tmo_d;
      num_q        <= num_d;
      idx_q        <= idx_d;
      img_cnt_q    <= img_cnt_d;
      hit_cnt_q    <= hit_cnt_d;
      tmo_err_q    <= tmo_err_d;
      match_q      <= match_d;
      pipe_rst_n_q <= pipe_rst_n_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (start) state_d = (num_img != '0) ? ST_FLUSH : ST_DONE;
      ST_FLUSH:    if (fl_q == FL_W'(FLUSH_CYCLES - 1)) state_d = ST_STREAM;
      ST_STREAM:   if (last_rd) state_d = ST_DRAIN;
      ST_DRAIN:    if (stream_done) state_d = ST_WAIT_DEC;
      ST_WAIT_DEC: if (bus.decision_valid || tmo_hit) state_d = ST_REPORT;
      ST_REPORT:   state_d = (img_cnt_inc == num_q) ? ST_DONE : ST_FLUSH;
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // counters, decision capture and scoreboard updates
  always_comb begin
    fl_d      = (state_q == ST_FLUSH)    ? fl_q + 1'b1  : '0;
    tmo_d     = (state_q == ST_WAIT_DEC) ? tmo_q + 1'b1 : '0;
    num_d     = num_q;
    idx_d     = idx_q;
    img_cnt_d = img_cnt_q;
    hit_cnt_d = hit_cnt_q;
    tmo_err_d = tmo_err_q;
    match_d   = match_q;

    if (accept) begin
      num_d     = num_img;
      idx_d     = '0;
      img_cnt_d = '0;
      hit_cnt_d = '0;
      tmo_err_d = 1'b0;
    end

    // a decision arriving on the expiry cycle still counts as a result
    if (state_q == ST_WAIT_DEC) begin
      match_d = bus.decision_valid && (bus.decision_in == bus.label_in);
      if (!bus.decision_valid && tmo_hit) tmo_err_d = 1'b1;
    end

    if (state_q == ST_REPORT) begin
      img_cnt_d = img_cnt_inc;
      hit_cnt_d = hit_cnt_q + IMG_BITS'(match_q);
      idx_d     = idx_q + 1'b1;
    end

    // registered so the datapath sees reset while rst_n is low
    pipe_rst_n_d = (state_d != ST_FLUSH);
  end

  // outputs decoded from the current state
  always_comb begin
    rd_en        = (state_q == ST_STREAM);
    idx_clr      = (state_q == ST_FLUSH);
    base_clr     = accept;
    base_inc     = (state_q == ST_REPORT);
    busy         = (state_q != ST_IDLE);
    result_valid = (state_q == ST_REPORT);
    result_match = (state_q == ST_REPORT) && match_q;
    done         = (state_q == ST_DONE);
  end

  assign bus.mem_rd_en  = rd_en;
  assign bus.label_addr = idx_q;
  assign bus.pipe_rst_n = pipe_rst_n_q;
  assign img_cnt        = img_cnt_q;
  assign hit_cnt        = hit_cnt_q;
  assign timeout_err    = tmo_err_q;

endmodule

// File: tb/tb_cnn_image_sequencer.sv
// Directed bench for the CNN image sequencer with ROM and decision models.
module tb_cnn_image_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [9:0] num_img;
  logic       busy, result_valid, result_match, timeout_err, done;
  logic [9:0] img_cnt, hit_cnt;

  int vecs = 0;
  int errs = 0;

  cnn_image_sequencer_if #(.ADDR_BITS(20), .IMG_BITS(10)) bus ();

  cnn_image_sequencer #(
    .IMG_PIXELS     (784),
    .PIX_IDX_BITS   (10),
    .IMG_BITS       (10),
    .ADDR_BITS      (20),
    .FLUSH_CYCLES   (3),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .num_img      (num_img),
    .bus          (bus),
    .busy         (busy),
    .result_valid (result_valid),
    .result_match (result_match),
    .img_cnt      (img_cnt),
    .hit_cnt      (hit_cnt),
    .timeout_err  (timeout_err),
    .done         (done)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] lbl(input int k);
    return 4'((k * 3 + 7) % 10);
  endfunction

  // image memory holds value = address mod 256, one-cycle read latency
  always @(posedge clk) bus.mem_rdata <= bus.mem_rd_en ? bus.mem_addr[7:0] : 8'h00;
  assign bus.label_in = lbl(int'(bus.label_addr));

  // decision model: answers 5 cycles after the 784th pixel of an image
  bit dec_on;
  bit stray_req;
  bit wrong [8];
  int ppix, cd, img_seen;
  initial begin
    bus.decision_valid = 1'b0;
    bus.decision_in    = 4'd0;
  end
  always @(negedge clk) begin
    bus.decision_valid = 1'b0;
    if (!rst_n) begin
      ppix = 0; cd = 0; img_seen = 0;
    end else begin
      if (result_valid) img_seen++;
      if (done) img_seen = 0;
      if (stray_req && bus.mem_rd_en) begin
        bus.decision_valid = 1'b1;
        bus.decision_in    = lbl(img_seen);
        stray_req          = 1'b0;
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          bus.decision_valid = 1'b1;
          bus.decision_in    = wrong[img_seen & 7] ? 4'((lbl(img_seen) + 1) % 10) : lbl(img_seen);
        end
      end
      if (bus.pix_valid) begin
        ppix++;
        if (ppix == 784) begin
          ppix = 0;
          if (dec_on) cd = 5;
        end
      end
    end
  end

  // observation counters, sampled on the falling edge
  int  cyc = 0;
  int  pix_cnt, seq_err, run, max_run, rd_cnt, addr_err, nimg_rd;
  int  flush_runs, flush_len, flush_cur, first_gap, rise_cyc;
  int  res_cnt, done_cnt, last_pix_cyc, last_gap;
  int  first_addr [8];
  bit  res_bits [8];
  bit  got_first_pix, prev_rd;
  always @(negedge clk) begin
    cyc++;
    if (bus.pix_valid) begin
      if (bus.pix_out !== 8'(pix_cnt)) seq_err++;
      pix_cnt++;
      run++;
      if (run > max_run) max_run = run;
      last_pix_cyc = cyc;
      if (!got_first_pix) begin
        got_first_pix = 1'b1;
        first_gap     = cyc - rise_cyc;
      end
    end else begin
      run = 0;
    end
    if (bus.mem_rd_en) begin
      if (bus.mem_addr !== 20'(rd_cnt)) addr_err++;
      if (!prev_rd && nimg_rd < 8) begin
        first_addr[nimg_rd] = int'(bus.mem_addr);
        nimg_rd++;
      end
      rd_cnt++;
    end
    prev_rd = bus.mem_rd_en;
    if (!bus.pipe_rst_n) begin
      flush_cur++;
    end else if (flush_cur > 0) begin
      flush_runs++;
      flush_len = flush_cur;
      rise_cyc  = cyc;
      flush_cur = 0;
    end
    if (result_valid) begin
      if (res_cnt < 8) res_bits[res_cnt] = result_match;
      res_cnt++;
      last_gap = cyc - last_pix_cyc;
    end
    if (done) done_cnt++;
  end

  task automatic clr_mon();
    pix_cnt = 0; seq_err = 0; run = 0; max_run = 0; rd_cnt = 0; addr_err = 0;
    nimg_rd = 0; flush_runs = 0; flush_len = 0; flush_cur = 0; first_gap = -1;
    rise_cyc = 0; res_cnt = 0; done_cnt = 0; last_pix_cyc = 0; last_gap = -1;
    got_first_pix = 1'b0;
    for (int i = 0; i < 8; i++) begin
      first_addr[i] = -1;
      res_bits[i]   = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input longint obs, input longint exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      $error("miscompare on %s", tag);
    end
  endtask

  task automatic kick(input int n);
    @(negedge clk);
    start   = 1'b1;
    num_img = 10'(n);
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int k;
    k = 0;
    while (done_cnt == 0 && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    chk(tag, longint'(done_cnt != 0), 1);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; num_img = '0;
    dec_on = 1'b1; stray_req = 1'b0;
    for (int i = 0; i < 8; i++) wrong[i] = 1'b0;
    clr_mon();

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_pipe_rst_n", bus.pipe_rst_n, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", bus.mem_rd_en, 0);
    chk("rst_pix_valid", bus.pix_valid, 0);
    chk("rst_img_cnt", img_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("pipe_rst_n_release", bus.pipe_rst_n, 1);

    // batch of 1 with a start while busy
    clr_mon();
    kick(1);
    repeat (100) @(negedge clk);
    start = 1'b1; num_img = 10'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done("b1_done", 2000);
    chk("b1_pix_cnt", pix_cnt, 784);
    chk("b1_pix_seq_err", seq_err, 0);
    chk("b1_pix_run", max_run, 784);
    chk("b1_rd_cnt", rd_cnt, 784);
    chk("b1_addr_err", addr_err, 0);
    chk("b1_flush_runs", flush_runs, 1);
    chk("b1_flush_len", flush_len, 3);
    chk("b1_flush_to_pix", first_gap, 2);
    chk("b1_res_cnt", res_cnt, 1);
    chk("b1_match", res_bits[0], 1);
    chk("b1_dec_gap", last_gap, 6);
    chk("b1_img_cnt", img_cnt, 1);
    chk("b1_hit_cnt", hit_cnt, 1);
    chk("b1_done_cnt", done_cnt, 1);
    chk("b1_busy", busy, 0);

    // batch of 3, image 1 gets a wrong decision
    clr_mon();
    wrong[1] = 1'b1;
    kick(3);
    wait_done("b3_done", 6000);
    chk("b3_res_cnt", res_cnt, 3);
    chk("b3_match0", res_bits[0], 1);
    chk("b3_match1", res_bits[1], 0);
    chk("b3_match2", res_bits[2], 1);
    chk("b3_img_cnt", img_cnt, 3);
    chk("b3_hit_cnt", hit_cnt, 2);
    chk("b3_done_cnt", done_cnt, 1);
    chk("b3_img2_addr", first_addr[2], 1568);
    chk("b3_img1_addr", first_addr[1], 784);
    chk("b3_pix_seq_err", seq_err, 0);
    chk("b3_pix_cnt", pix_cnt, 2352);
    chk("b3_flush_runs", flush_runs, 3);
    chk("b3_timeout_err", timeout_err, 0);
    wrong[1] = 1'b0;

    // empty batch: done right after IDLE, counters cleared
    clr_mon();
    kick(0);
    chk("z_done", done, 1);
    chk("z_img_cnt", img_cnt, 0);
    chk("z_hit_cnt", hit_cnt, 0);
    @(negedge clk);
    chk("z_done_drop", done, 0);
    chk("z_busy", busy, 0);
    chk("z_rd_cnt", rd_cnt, 0);

    // no decisions: both images time out, batch still completes
    clr_mon();
    dec_on = 1'b0;
    kick(2);
    wait_done("t_done", 4000);
    chk("t_res_cnt", res_cnt, 2);
    chk("t_match0", res_bits[0], 0);
    chk("t_match1", res_bits[1], 0);
    chk("t_gap", last_gap, 65);
    chk("t_timeout_err", timeout_err, 1);
    chk("t_img_cnt", img_cnt, 2);
    chk("t_hit_cnt", hit_cnt, 0);
    dec_on = 1'b1;

    // stray decision during STREAM must be ignored
    clr_mon();
    wrong[0]  = 1'b1;
    stray_req = 1'b1;
    kick(1);
    wait_done("s_done", 2000);
    chk("s_stray_used", longint'(stray_req), 0);
    chk("s_res_cnt", res_cnt, 1);
    chk("s_match", res_bits[0], 0);
    chk("s_hit_cnt", hit_cnt, 0);
    chk("s_timeout_err_clr", timeout_err, 0);
    wrong[0] = 1'b0;

    // reset during STREAM of the second image of five
    clr_mon();
    kick(5);
    for (int k = 0; k < 3000 && !(res_cnt == 1 && bus.mem_rd_en); k++) @(negedge clk);
    chk("r_reached_img2", longint'(res_cnt == 1 && bus.mem_rd_en), 1);
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("r_pipe_rst_n", bus.pipe_rst_n, 0);
    chk("r_busy", busy, 0);
    chk("r_rd_en", bus.mem_rd_en, 0);
    chk("r_mem_addr", bus.mem_addr, 0);
    chk("r_pix_valid", bus.pix_valid, 0);
    chk("r_pix_out", bus.pix_out, 0);
    chk("r_label_addr", bus.label_addr, 0);
    chk("r_img_cnt", img_cnt, 0);
    chk("r_hit_cnt", hit_cnt, 0);
    @(negedge clk);
    chk("r_no_done", done_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("r_pipe_rst_n_rel", bus.pipe_rst_n, 1);
    clr_mon();
    kick(1);
    wait_done("r2_done", 2000);
    chk("r2_first_addr", first_addr[0], 0);
    chk("r2_pix_seq_err", seq_err, 0);
    chk("r2_img_cnt", img_cnt, 1);
    chk("r2_hit_cnt", hit_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
